polar_enc_ctrl: RTL and testbench

- Frame-level controller and sequencer for the polar transform datapath.
- Accepts K-bit messages over a valid/ready handshake and places them into the information positions of an N-bit u-vector; frozen positions are zero.
- Runs the log2(N) butterfly stages one stage per clock, then presents the N-bit codeword over a valid/ready handshake.
- Sits between the message source and the rate-matching/modulator stage.

---
 rtl/polar_pkg.sv | 37 +++
 rtl/polar_bfly_stage.sv | 34 +++
 rtl/polar_enc_ctrl.sv | 117 +++++++++++
 tb/tb_polar_enc_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/polar_pkg.sv
// Shared types and elaboration-time helpers for the polar encoder controller.
// The mask helpers work on a 1024-bit container, the largest supported N.
package polar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int MAXN = 1024;

  function automatic int popcount(input logic [MAXN-1:0] mask);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAXN; i++) begin
      if (mask[i]) cnt++;
    end
    return cnt;
  endfunction

  // Index of the m-th set bit of mask, counting from the LSB.
  function automatic int info_pos(input logic [MAXN-1:0] mask, input int m);
    int seen;
    int pos;
    seen = 0;
    pos  = 0;
    for (int i = 0; i < MAXN; i++) begin
      if (mask[i]) begin
        if (seen == m) pos = i;
        seen++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/polar_bfly_stage.sv
// One polar butterfly stage, selected at run time by stage_i.
// Every stage is precomputed as static wiring; the stage index only drives the final mux.
module polar_bfly_stage
  import polar_pkg::*;
#(
  parameter int N     = 8,
  parameter int LOG2N = $clog2(N),
  parameter int SW    = 2
) (
  input  logic [N-1:0]  w_i,
  input  logic [SW-1:0] stage_i,
  output logic [N-1:0]  w_o
);

  logic [N-1:0] stage_res [LOG2N];

  for (genvar gs = 0; gs < LOG2N; gs++) begin : g_stage
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      if (((gi >> gs) & 1) == 0) begin : g_upper
        assign stage_res[gs][gi] = w_i[gi] ^ w_i[gi + (1 << gs)];
      end else begin : g_lower
        assign stage_res[gs][gi] = w_i[gi];
      end
    end
  end

  always_comb begin
    w_o = w_i;
    for (int s = 0; s < LOG2N; s++) begin
      if (stage_i == SW'(s)) w_o = stage_res[s];
    end
  end

endmodule

// File: rtl/polar_enc_ctrl.sv
// Polar encoder frame controller: maps a K-bit message onto the information set,
// runs one butterfly stage per clock, then holds the codeword until accepted.
module polar_enc_ctrl
  import polar_pkg::*;
#(
  parameter int           N         = 8,
  parameter int           K         = 4,
  parameter logic [N-1:0] INFO_MASK = 8'b1110_1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy,
  output logic [15:0]  frame_cnt
);

  localparam int LOG2N = $clog2(N);
  localparam int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1;

  if (popcount(MAXN'(INFO_MASK)) != K) begin : g_bad_mask
    $error("polar_enc_ctrl: popcount(INFO_MASK) must equal K");
  end

  logic [N-1:0] u_map;
  logic [N-1:0] w_stage;

  // Frozen positions tie to zero; message bit m lands on the m-th set mask bit.
  for (genvar gi = 0; gi < N; gi++) begin : g_frozen
    if (!INFO_MASK[gi]) begin : g_zero
      assign u_map[gi] = 1'b0;
    end
  end
  for (genvar gi = 0; gi < K; gi++) begin : g_info
    localparam int POS = info_pos(MAXN'(INFO_MASK), gi);
    assign u_map[POS] = in_data[gi];
  end

  state_e        state_q, state_d;
  logic [N-1:0]  w_q, w_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [15:0]   cnt_q, cnt_d;

  polar_bfly_stage #(
    .N     (N),
    .LOG2N (LOG2N),
    .SW    (SW)
  ) u_bfly (
    .w_i     (w_q),
    .stage_i (stage_q),
    .w_o     (w_stage)
  );

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          w_d     = u_map;
          stage_d = '0;
          state_d = ENC;
        end
      end
      ENC: begin
        w_d = w_stage;
        if (stage_q == SW'(LOG2N - 1)) begin
          stage_d = '0;
          state_d = OUT;
        end else begin
          stage_d = stage_q + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          cnt_d = cnt_q + 16'd1;
          // Reloading here keeps back-to-back frames free of an IDLE bubble.
          if (in_valid) begin
            w_d     = u_map;
            stage_d = '0;
            state_d = ENC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == OUT) && out_ready);
  assign out_valid = (state_q == OUT);
  assign out_data  = w_q;
  assign busy      = (state_q != IDLE);
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_polar_enc_ctrl.sv
// Self-checking bench for polar_enc_ctrl against a generator-matrix reference model.
module tb_polar_enc_ctrl;

  localparam int           N         = 8;
  localparam int           K         = 4;
  localparam int           LOG2N     = 3;
  localparam logic [N-1:0] INFO_MASK = 8'b1110_1000;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         busy;
  logic [15:0]  frame_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  polar_enc_ctrl #(
    .N         (N),
    .K         (K),
    .INFO_MASK (INFO_MASK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // x = u * G with G = F^(kron n); G[i][j] = 1 exactly when the bits of j are a subset of the bits of i.
  function automatic logic [N-1:0] model(input logic [K-1:0] d);
    logic [N-1:0] u;
    logic [N-1:0] x;
    int m;
    u = '0;
    x = '0;
    m = 0;
    for (int i = 0; i < N; i++) begin
      if (INFO_MASK[i]) begin
        u[i] = d[m];
        m++;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (u[i]) begin
        for (int j = 0; j < N; j++) begin
          if ((j & ~i) == 0) x[j] = ~x[j];
        end
      end
    end
    return x;
  endfunction

  // Starts with the DUT idle, one time unit after a rising edge.
  task automatic run_frame(input logic [K-1:0] d, input int hold);
    logic [N-1:0] exp;
    int lat;
    exp = model(d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    chk("accept_busy", 32'(busy), 32'd1);
    in_data = K'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(lat), 32'(LOG2N));
    chk("codeword", 32'(out_data), 32'(exp));
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      chk("hold_data", 32'(out_data), 32'(exp));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_cnt", 32'(frame_cnt), 32'(exp_cnt));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_cnt++;
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    chk("out_valid_drop", 32'(out_valid), 32'd0);
  endtask

  logic [K-1:0] b2b_in [8];
  logic [N-1:0] b2b_exp [8];

  initial begin
    int sent;
    int got;
    int last;
    int cyc;
    int saw;
    logic acc;
    logic dlv;

    // Reset with in_valid asserted must leave the controller idle.
    rst = 1'b1; in_valid = 1'b1; in_data = 4'b1111; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;

    // Directed frames, including the model sanity anchors from the known vectors.
    chk("model_0001", 32'(model(4'b0001)), 32'h0F);
    chk("model_1111", 32'(model(4'b1111)), 32'h96);
    run_frame(4'b0001, 0);
    run_frame(4'b1000, 0);
    run_frame(4'b1111, 0);
    run_frame(4'b0000, 0);
    run_frame(4'b1111, 10);

    for (int f = 0; f < 16; f++) begin
      run_frame(K'($urandom), int'($urandom_range(0, 3)));
    end

    // Back-to-back stream with in_valid and out_ready held high.
    b2b_in[0] = 4'b0001; b2b_in[1] = 4'b1000; b2b_in[2] = 4'b1111;
    for (int i = 3; i < 8; i++) b2b_in[i] = K'($urandom);
    for (int i = 0; i < 8; i++) b2b_exp[i] = model(b2b_in[i]);
    out_ready = 1'b1; in_valid = 1'b1; in_data = b2b_in[0];
    sent = 0; got = 0; last = -1; cyc = 0;
    while (got < 8 && cyc < 200) begin
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      if (dlv) begin
        chk("b2b_data", 32'(out_data), 32'(b2b_exp[got]));
        if (last >= 0) chk("b2b_spacing", 32'(cyc - last), 32'(LOG2N + 1));
        last = cyc;
        got++;
        exp_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 8) in_data = b2b_in[sent];
        else in_valid = 1'b0;
      end
    end
    chk("b2b_delivered", 32'(got), 32'd8);
    out_ready = 1'b0;
    chk("b2b_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    @(posedge clk); #1;

    // Abort: reset lands in the second ENC cycle; no codeword may appear.
    in_valid = 1'b1; in_data = 4'b0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
    out_ready = 1'b1;
    saw = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) saw = 1;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk("abort_no_valid", 32'(saw), 32'd0);
    chk("abort_frame_cnt", 32'(frame_cnt), 32'd0);
    run_frame(4'b0001, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
